inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch unit for the single-cycle core. It owns the architectural PC and fetches each instruction from instruction memory over a request/grant/response handshake. It presents `instr`/`pc` to decode and execute, then takes the `NextPC` computed by the execute stage to start the next fetch. This closes the PC loop from the opposite end of the execute stage's `NextPC` output. It also counts retired instructions and flags misaligned targets.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset; must be 4-byte aligned.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset).
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address; equals `pc`.
- `imem_gnt` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: read data valid.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: held instruction for decode/execute.
- `pc` out 32: address of `instr`.
- `instr_valid` out 1: `instr`/`pc` are valid and stable.
- `next_pc` in 32: target from execute (`NextPC`).
- `next_pc_valid` in 1: current instruction completes; `next_pc` is valid.
- `fault` out 1: sticky misaligned-target flag.
- `instret` out 32: retired-instruction counter.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, FAULT. All are registered.
- Reset (`rst`=0 at an edge) sets the following:
  - state=IDLE, `pc`=RESET_PC, `instr`=0, `instret`=0, `fault`=0.
  - All outputs derived from state are 0: `imem_req`, `instr_valid`.
- IDLE: always moves to REQ on the next edge.
- REQ:
  - `imem_req`=1, `imem_addr`=`pc`.
  - Address and request stay stable until `imem_gnt`=1.
  - On `imem_gnt`=1, go to WAIT.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid`=1: `instr`<=`imem_rdata`, go to HOLD.
  - Memory never asserts `rvalid` in the same cycle as `gnt`.
- HOLD:
  - `instr_valid`=1; `instr` and `pc` are held.
  - On `next_pc_valid`=1 with `next_pc[1:0]`==0: `pc`<=`next_pc`, `instret`<=`instret`+1 (mod 2^32, wraps to 0), go to REQ.
  - On `next_pc_valid`=1 with `next_pc[1:0]`!=0: `fault`<=1, go to FAULT. `pc` and `instret` are unchanged.
- FAULT:
  - `instr_valid`=0 and `imem_req`=0.
  - The unit stays here until reset; `fault` stays 1.
- Inputs ignored outside their state:
  - `next_pc_valid` outside HOLD.
  - `imem_rvalid` outside WAIT, including a stale response to a request aborted by reset.
  - `imem_gnt` outside REQ.
- Reset takes priority over every transition in every state, including mid-REQ and mid-WAIT.

## Timing
- Outputs `imem_req`, `instr_valid` and `fault` decode from registered state only; they have no combinational input paths.
- `imem_addr`, `pc`, `instr` and `instret` are registers.
- First request: `rst` rises before edge E0. IDLE→REQ at E0, so `imem_req`=1 in the cycle after E0.
- Zero-wait memory, where `gnt` is high in the REQ cycle and `rvalid` is high the next cycle:
  - REQ (cycle n), WAIT (n+1), HOLD (n+2).
  - `instr_valid`=1 from cycle n+2.
- Steady state: if `next_pc_valid` is asserted in the first HOLD cycle, the loop repeats every 3 cycles (HOLD, REQ, WAIT).
- `instr_valid` drops in the cycle after `next_pc_valid` is accepted.
- The new `pc` is visible on `imem_addr` in that same cycle.

## Test plan
- Reset and first fetch:
  - Stimulus: hold `rst`=0 for 3 cycles, then release, with `RESET_PC`=0.
  - Required: outputs are 0 during reset. `imem_req`=1 with `imem_addr`=0 exactly one cycle after release.
- Zero-wait fetch:
  - Stimulus: `gnt`=1 immediately, `rvalid`=1 with `rdata`=0x00500093 one cycle later.
  - Required: `instr`=0x00500093, `pc`=0 and `instr_valid`=1 two cycles after `req` rises.
- Grant back-pressure:
  - Stimulus: hold `gnt`=0 for 4 cycles in REQ.
  - Required: `imem_req`=1 and `imem_addr` are stable throughout; no transition until `gnt`.
- Sequential and jump:
  - Stimulus: `next_pc`=0x4, then `next_pc`=0x80.
  - Required: the following fetches use 0x4 and then 0x80; `instret`=1, then 2.
- Misaligned target:
  - Stimulus: `next_pc`=0x102 in HOLD.
  - Required: `fault`=1 next cycle, `instr_valid`=0, `imem_req` stays 0 for 10 or more cycles, `pc` is unchanged.
  - A subsequent reset clears `fault`.
- Reset mid-WAIT:
  - Stimulus: assert `rst`=0 in WAIT, with `rvalid`=1 arriving during reset and in the first cycle after release.
  - Required: `instr` stays 0, `instr_valid` stays 0, and a fresh REQ to `RESET_PC` is issued.

Source files
------------

// File: rtl/imem_if.sv
// Instruction-memory request/grant/response bus between the fetch unit and memory.
interface imem_if;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   // Fetch side drives the request; memory answers with grant and read data.
   modport master (
      output req,
      output addr,
      input  gnt,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output gnt,
      output rvalid,
      output rdata
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the architectural PC, fetches one instruction at a
// time over the imem handshake, holds it for decode/execute and advances on NextPC.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   imem_if.master       imem,
   output logic [31:0]  instr,
   output logic [31:0]  pc,
   output logic         instr_valid,
   input  logic [31:0]  next_pc,
   input  logic         next_pc_valid,
   output logic         fault,
   output logic [31:0]  instret
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      FAULT = 3'd4
   } state_t;

   state_t      state;
   logic        req_q;
   logic        target_aligned;

   // A target is usable only if it lands on a word boundary.
   assign target_aligned = (next_pc[1:0] == 2'b00);

   // The fetch address is the PC register itself, so it is stable for the whole REQ.
   assign imem.addr = pc;
   assign imem.req  = req_q;

   // Fetch sequencer: state, PC, held instruction, retire count and all
   // state-derived outputs are updated together so every output is a flop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         instr       <= 32'h0000_0000;
         instret     <= 32'h0000_0000;
         fault       <= 1'b0;
         req_q       <= 1'b0;
         instr_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= REQ;
               req_q <= 1'b1;
            end

            REQ: begin
               // Hold request and address until memory accepts.
               if (imem.gnt) begin
                  state <= WAIT;
                  req_q <= 1'b0;
               end
            end

            WAIT: begin
               if (imem.rvalid) begin
                  instr       <= imem.rdata;
                  state       <= HOLD;
                  instr_valid <= 1'b1;
               end
            end

            HOLD: begin
               if (next_pc_valid) begin
                  instr_valid <= 1'b0;
                  if (target_aligned) begin
                     pc      <= next_pc;
                     instret <= instret + 32'd1;
                     state   <= REQ;
                     req_q   <= 1'b1;
                  end else begin
                     // Misaligned target: freeze PC and count, wait for reset.
                     fault <= 1'b1;
                     state <= FAULT;
                  end
               end
            end

            FAULT: begin
               state       <= FAULT;
               fault       <= 1'b1;
               req_q       <= 1'b0;
               instr_valid <= 1'b0;
            end

            default: begin
               state       <= IDLE;
               req_q       <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized fetch/retire
// traffic checked against a transaction-level model (expected PC, retire count, memory).
module tb_inst_fetch;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_valid;
   logic [31:0] next_pc;
   logic        next_pc_valid;
   logic        fault;
   logic [31:0] instret;

   imem_if bus ();

   inst_fetch #(.RESET_PC(RESET_PC)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .imem          (bus),
      .instr         (instr),
      .pc            (pc),
      .instr_valid   (instr_valid),
      .next_pc       (next_pc),
      .next_pc_valid (next_pc_valid),
      .fault         (fault),
      .instret       (instret)
   );

   // Reference model state: architectural PC, retire count, last delivered word.
   logic [31:0] exp_pc;
   logic [31:0] exp_ret;
   logic [31:0] exp_instr;
   int          n_pass;
   int          n_chk;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got running required finished");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", tag, obs, exp);
   endtask

   task automatic drive_idle();
      bus.gnt       = 1'b0;
      bus.rvalid    = 1'b0;
      bus.rdata     = 32'h0;
      next_pc_valid = 1'b0;
      next_pc       = 32'h0;
   endtask

   // Hold reset for n cycles checking cleared outputs, release, expect REQ one cycle later.
   task automatic do_reset(input int n);
      rst = 1'b0;
      drive_idle();
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         check("rst_req",     {31'h0, bus.req},     32'h0);
         check("rst_ivalid",  {31'h0, instr_valid}, 32'h0);
         check("rst_fault",   {31'h0, fault},       32'h0);
         check("rst_instr",   instr,                32'h0);
         check("rst_instret", instret,              32'h0);
         check("rst_pc",      pc,                   RESET_PC);
         @(negedge clk);
      end
      rst     = 1'b1;
      exp_pc  = RESET_PC;
      exp_ret = 32'h0;
      @(negedge clk);
      check("first_req",  {31'h0, bus.req}, 32'h1);
      check("first_addr", bus.addr,         RESET_PC);
   endtask

   // Serve one fetch with gdly grant stalls and rdly response stalls, returning word.
   task automatic fetch(input logic [31:0] word, input int gdly, input int rdly);
      int waited;
      waited = 0;
      while (bus.req !== 1'b1 && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      check("req_seen", {31'h0, bus.req}, 32'h1);
      for (int i = 0; i < gdly; i++) begin
         check("req_stall",  {31'h0, bus.req}, 32'h1);
         check("addr_stall", bus.addr,         exp_pc);
         bus.gnt       = 1'b0;
         bus.rvalid    = 1'($urandom_range(0, 1));
         bus.rdata     = $urandom;
         next_pc_valid = 1'($urandom_range(0, 1));
         next_pc       = $urandom;
         @(negedge clk);
      end
      check("req_addr", bus.addr, exp_pc);
      bus.gnt       = 1'b1;
      bus.rvalid    = 1'b0;
      next_pc_valid = 1'b0;
      @(negedge clk);
      bus.gnt = 1'b0;
      check("req_drop",    {31'h0, bus.req},     32'h0);
      check("wait_ivalid", {31'h0, instr_valid}, 32'h0);
      for (int i = 0; i < rdly; i++) begin
         bus.gnt       = 1'($urandom_range(0, 1));
         next_pc_valid = 1'($urandom_range(0, 1));
         next_pc       = {$urandom_range(0, 255), 2'b00};
         bus.rvalid    = 1'b0;
         @(negedge clk);
         check("wait_ivalid", {31'h0, instr_valid}, 32'h0);
         check("wait_noreq",  {31'h0, bus.req},     32'h0);
      end
      bus.gnt       = 1'b0;
      next_pc_valid = 1'b0;
      bus.rvalid    = 1'b1;
      bus.rdata     = word;
      @(negedge clk);
      bus.rvalid = 1'b0;
      exp_instr  = word;
      check("hold_ivalid",  {31'h0, instr_valid}, 32'h1);
      check("hold_instr",   instr,                word);
      check("hold_pc",      pc,                   exp_pc);
      check("hold_instret", instret,              exp_ret);
   endtask

   // Keep HOLD for hdly cycles under noise, then present target as NextPC.
   task automatic retire(input logic [31:0] target, input int hdly);
      for (int i = 0; i < hdly; i++) begin
         check("hold_stable_iv",    {31'h0, instr_valid}, 32'h1);
         check("hold_stable_instr", instr,                exp_instr);
         check("hold_stable_pc",    pc,                   exp_pc);
         bus.gnt    = 1'($urandom_range(0, 1));
         bus.rvalid = 1'($urandom_range(0, 1));
         bus.rdata  = $urandom;
         @(negedge clk);
      end
      bus.gnt       = 1'b0;
      bus.rvalid    = 1'b0;
      next_pc       = target;
      next_pc_valid = 1'b1;
      @(negedge clk);
      next_pc_valid = 1'b0;
      if (target[1:0] == 2'b00) begin
         exp_pc  = target;
         exp_ret = exp_ret + 32'd1;
         check("ret_ivalid",  {31'h0, instr_valid}, 32'h0);
         check("ret_req",     {31'h0, bus.req},     32'h1);
         check("ret_addr",    bus.addr,             target);
         check("ret_instret", instret,              exp_ret);
         check("ret_fault",   {31'h0, fault},       32'h0);
      end else begin
         check("flt_fault",   {31'h0, fault},       32'h1);
         check("flt_ivalid",  {31'h0, instr_valid}, 32'h0);
         check("flt_req",     {31'h0, bus.req},     32'h0);
         check("flt_pc",      pc,                   exp_pc);
         check("flt_instret", instret,              exp_ret);
         for (int i = 0; i < 10; i++) begin
            bus.gnt       = 1'($urandom_range(0, 1));
            bus.rvalid    = 1'($urandom_range(0, 1));
            bus.rdata     = $urandom;
            next_pc_valid = 1'($urandom_range(0, 1));
            next_pc       = {$urandom_range(0, 255), 2'b00};
            @(negedge clk);
            check("flt_stay_req",   {31'h0, bus.req},     32'h0);
            check("flt_stay_fault", {31'h0, fault},       32'h1);
            check("flt_stay_iv",    {31'h0, instr_valid}, 32'h0);
            check("flt_stay_pc",    pc,                   exp_pc);
         end
         drive_idle();
      end
   endtask

   initial begin
      logic [31:0] tgt;
      n_pass    = 0;
      n_chk     = 0;
      exp_instr = 32'h0;
      rst       = 1'b0;
      drive_idle();

      // Reset, first fetch at zero wait, then back-pressure, sequential and jump.
      do_reset(3);
      fetch(32'h0050_0093, 0, 0);
      retire(32'h0000_0004, 0);
      fetch(mem_word(32'h4), 4, 1);
      retire(32'h0000_0080, 1);
      fetch(mem_word(32'h80), 0, 2);
      check("instret_two", instret, 32'd2);

      // Misaligned target faults; reset clears it.
      retire(32'h0000_0102, 0);
      do_reset(2);
      check("fault_cleared", {31'h0, fault}, 32'h0);

      // Randomized fetch/retire traffic.
      for (int it = 0; it < 60; it++) begin
         fetch(mem_word(exp_pc), $urandom_range(0, 3), $urandom_range(0, 3));
         case ($urandom_range(0, 9))
            0:       tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} | 32'h1;
            1, 2, 3: tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            default: tgt = exp_pc + 32'd4;
         endcase
         retire(tgt, $urandom_range(0, 2));
         if (tgt[1:0] != 2'b00) do_reset(1);
      end

      // Reset while waiting for the response, with stale rvalid around the release.
      while (bus.req !== 1'b1) @(negedge clk);
      bus.gnt = 1'b1;
      @(negedge clk);
      bus.gnt    = 1'b0;
      rst        = 1'b0;
      bus.rvalid = 1'b1;
      bus.rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      check("mw_instr",  instr,                32'h0);
      check("mw_ivalid", {31'h0, instr_valid}, 32'h0);
      check("mw_req",    {31'h0, bus.req},     32'h0);
      rst = 1'b1;
      @(negedge clk);
      check("mw_rel_instr",  instr,                32'h0);
      check("mw_rel_ivalid", {31'h0, instr_valid}, 32'h0);
      check("mw_rel_req",    {31'h0, bus.req},     32'h1);
      check("mw_rel_addr",   bus.addr,             RESET_PC);
      @(negedge clk);
      bus.rvalid = 1'b0;
      check("mw_after_instr",  instr,                32'h0);
      check("mw_after_ivalid", {31'h0, instr_valid}, 32'h0);
      check("mw_after_req",    {31'h0, bus.req},     32'h1);
      exp_pc  = RESET_PC;
      exp_ret = 32'h0;
      fetch(mem_word(RESET_PC), 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
